// File: rtl/tdc_pkg.sv
// Shared TDC definitions: parameter defaults, a width helper and the
// timestamp layout also used by the readout block.
package tdc_pkg;

  localparam int NFF_DEF      = 200;
  localparam int FINE_W_DEF   = 8;
  localparam int COARSE_W_DEF = 24;
  localparam int GRP_DEF      = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  typedef struct packed {
    logic [COARSE_W_DEF-1:0] coarse;
    logic [FINE_W_DEF-1:0]   fine;
  } timestamp_t;

endpackage

// File: rtl/tdc_popcount.sv
// Two-stage registered popcount: group partial sums, then the final sum.
// Data-only pipeline; the caller tracks validity alongside it.
module tdc_popcount
  import tdc_pkg::*;
#(
  parameter int WIDTH = NFF_DEF,
  parameter int GRP   = GRP_DEF,
  parameter int OUT_W = FINE_W_DEF
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] data,
  output logic [OUT_W-1:0] count
);

  localparam int NG    = (WIDTH + GRP - 1) / GRP;
  localparam int PAD_W = NG * GRP;
  localparam int GW    = clog2(GRP + 1);

  logic [PAD_W-1:0] padded;
  logic [GW-1:0]    grp_d [NG];
  logic [GW-1:0]    grp_q [NG];
  logic [GW-1:0]    grp_acc;
  logic [OUT_W-1:0] sum_d;

  // Zero padding lets the last group be partial without special cases.
  assign padded = PAD_W'(data);

  always_comb begin
    grp_acc = '0;
    for (int g = 0; g < NG; g++) begin
      grp_acc = '0;
      for (int j = 0; j < GRP; j++) begin
        grp_acc = grp_acc + GW'(padded[g*GRP + j]);
      end
      grp_d[g] = grp_acc;
    end
  end

  always_ff @(posedge clk) begin
    grp_q <= grp_d;
  end

  always_comb begin
    sum_d = '0;
    for (int g = 0; g < NG; g++) begin
      sum_d = sum_d + OUT_W'(grp_q[g]);
    end
  end

  always_ff @(posedge clk) begin
    count <= sum_d;
  end

endmodule

// File: rtl/thermo_decoder.sv
// Thermometer-code TDC decoder: hit detection, bubble filter, popcount and
// coarse tagging, with a one-entry output register and drop counter.
module thermo_decoder
  import tdc_pkg::*;
#(
  parameter int NFF      = NFF_DEF,
  parameter int FINE_W   = FINE_W_DEF,
  parameter int COARSE_W = COARSE_W_DEF,
  parameter int GRP      = GRP_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NFF-1:0]      therm_in,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [FINE_W-1:0]   ts_fine,
  output logic [15:0]         drop_cnt
);

  logic                prev0;
  logic                hit;
  logic [COARSE_W-1:0] coarse_q;
  logic [COARSE_W-1:0] coarse_s1, coarse_s2, coarse_s3;
  logic                valid_s1, valid_s2, valid_s3;
  logic [NFF+1:0]      ext;
  logic [NFF-1:0]      bubble_d;
  logic [NFF-1:0]      bubble_s1;
  logic [FINE_W-1:0]   fine_s3;
  logic                load;

  assign hit = en & therm_in[0] & ~prev0;

  // Edge-extended code: below bit0 repeats bit0, above the top is zero.
  assign ext = {1'b0, therm_in, therm_in[0]};

  always_comb begin
    bubble_d = '0;
    for (int k = 0; k < NFF; k++) begin
      bubble_d[k] = (ext[k] & ext[k+1]) | (ext[k] & ext[k+2]) | (ext[k+1] & ext[k+2]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev0     <= 1'b0;
      coarse_q  <= '0;
      valid_s1  <= 1'b0;
      valid_s2  <= 1'b0;
      valid_s3  <= 1'b0;
      coarse_s1 <= '0;
      coarse_s2 <= '0;
      coarse_s3 <= '0;
    end else begin
      prev0     <= therm_in[0];
      coarse_q  <= coarse_q + COARSE_W'(1);
      valid_s1  <= hit;
      valid_s2  <= valid_s1;
      valid_s3  <= valid_s2;
      coarse_s1 <= coarse_q;
      coarse_s2 <= coarse_s1;
      coarse_s3 <= coarse_s2;
    end
  end

  // Code is only meaningful when valid_s1 is set, so it needs no reset.
  always_ff @(posedge clk) begin
    bubble_s1 <= bubble_d;
  end

  tdc_popcount #(
    .WIDTH (NFF),
    .GRP   (GRP),
    .OUT_W (FINE_W)
  ) u_popcount (
    .clk   (clk),
    .data  (bubble_s1),
    .count (fine_s3)
  );

  assign load = valid_s3 & (~ts_valid | ts_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_valid  <= 1'b0;
      ts_coarse <= '0;
      ts_fine   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (load) begin
        ts_valid  <= 1'b1;
        ts_coarse <= coarse_s3;
        ts_fine   <= fine_s3;
      end else if (ts_ready) begin
        ts_valid  <= 1'b0;
      end
      if (valid_s3 && !load && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_thermo_decoder.sv
// Self-checking bench for thermo_decoder: code table, directed corner
// sequences and random traffic against a cycle-level scoreboard.
module tb_thermo_decoder;
  import tdc_pkg::*;

  localparam int NFF      = 200;
  localparam int FINE_W   = 8;
  localparam int COARSE_W = 24;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic                ts_ready;
  logic [NFF-1:0]      therm_in;
  logic                ts_valid;
  logic [COARSE_W-1:0] ts_coarse;
  logic [FINE_W-1:0]   ts_fine;
  logic [15:0]         drop_cnt;
  logic                w4_valid;
  logic [3:0]          w4_coarse;
  logic [FINE_W-1:0]   w4_fine;
  logic [15:0]         w4_drop;

  always #5 clk = ~clk;

  thermo_decoder #(.NFF(NFF), .FINE_W(FINE_W), .COARSE_W(COARSE_W), .GRP(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .therm_in(therm_in),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_coarse(ts_coarse),
    .ts_fine(ts_fine), .drop_cnt(drop_cnt)
  );

  thermo_decoder #(.NFF(NFF), .FINE_W(FINE_W), .COARSE_W(4), .GRP(8)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .en(en), .therm_in(therm_in),
    .ts_valid(w4_valid), .ts_ready(ts_ready), .ts_coarse(w4_coarse),
    .ts_fine(w4_fine), .drop_cnt(w4_drop)
  );

  typedef struct {
    logic valid;
    int   cyc;
    int   fine;
  } result_t;

  typedef struct {
    logic [NFF-1:0] code;
    int             fine;
  } vec_t;

  result_t pipe_q[$];
  result_t held;
  int      m_drop;
  int      m_cyc;
  logic    m_prev0;
  int      compared   = 0;
  int      mismatched = 0;
  vec_t    vecs[8];

  function automatic logic [NFF-1:0] ones(input int n);
    logic [NFF-1:0] v;
    for (int i = 0; i < NFF; i++) v[i] = (i < n);
    return v;
  endfunction

  // Ones count after majority-of-three smoothing of the sampled code.
  function automatic int bubble_count(input logic [NFF-1:0] t);
    int cnt, lo, hi;
    cnt = 0;
    for (int k = 0; k < NFF; k++) begin
      if (k == 0) lo = int'(t[0]); else lo = int'(t[k-1]);
      if (k == NFF-1) hi = 0; else hi = int'(t[k+1]);
      if (lo + int'(t[k]) + hi >= 2) cnt++;
    end
    return cnt;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("ts_valid", 32'(ts_valid), 32'(held.valid));
    checkOutput("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    checkOutput("w4_valid", 32'(w4_valid), 32'(held.valid));
    checkOutput("w4_drop", 32'(w4_drop), 32'(m_drop));
    if (held.valid) begin
      checkOutput("ts_coarse", 32'(ts_coarse), 32'(held.cyc % (1 << COARSE_W)));
      checkOutput("ts_fine", 32'(ts_fine), 32'(held.fine));
      checkOutput("w4_coarse", 32'(w4_coarse), 32'(held.cyc % 16));
      checkOutput("w4_fine", 32'(w4_fine), 32'(held.fine));
    end
  endtask

  // Called at a falling edge: drive, advance the model one clock, then check.
  task automatic applyStimulus(input logic [NFF-1:0] code, input logic en_v, input logic ready_v);
    result_t r, arr;
    logic    h;
    therm_in = code;
    en       = en_v;
    ts_ready = ready_v;
    h        = en_v && code[0] && !m_prev0;
    m_prev0  = code[0];
    r.valid  = h;
    r.cyc    = m_cyc;
    r.fine   = h ? bubble_count(code) : 0;
    pipe_q.push_back(r);
    arr = pipe_q.pop_front();
    if (arr.valid) begin
      if (!held.valid || ready_v) held = arr;
      else if (m_drop < 65535) m_drop++;
    end else if (ready_v) begin
      held.valid = 1'b0;
    end
    m_cyc++;
    @(posedge clk);
    @(negedge clk);
    checkModel();
  endtask

  task automatic doReset();
    result_t idle;
    idle.valid = 1'b0;
    idle.cyc   = 0;
    idle.fine  = 0;
    rst_n    = 1'b0;
    therm_in = '0;
    en       = 1'b1;
    ts_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pipe_q.delete();
    for (int i = 0; i < 3; i++) pipe_q.push_back(idle);
    held    = idle;
    m_drop  = 0;
    m_cyc   = 0;
    m_prev0 = 1'b0;
    checkOutput("reset_valid", 32'(ts_valid), 32'd0);
    checkOutput("reset_coarse", 32'(ts_coarse), 32'd0);
    checkOutput("reset_fine", 32'(ts_fine), 32'd0);
    checkOutput("reset_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NFF-1:0] v;
    int             cyc_at_hit;
    int             seen;
    int             seen_fine;

    vecs[0].code = ones(37);  vecs[0].fine = 37;
    v = ones(50); v[20] = 1'b0; v[52] = 1'b1;
    vecs[1].code = v;         vecs[1].fine = 50;
    vecs[2].code = '1;        vecs[2].fine = 200;
    vecs[3].code = ones(1);   vecs[3].fine = 1;
    v = ones(30); v[10] = 1'b0; v[11] = 1'b0;
    vecs[4].code = v;         vecs[4].fine = 28;
    v = '0; v[0] = 1'b1; v[2] = 1'b1;
    vecs[5].code = v;         vecs[5].fine = 2;
    v = ones(100); v[150] = 1'b1; v[151] = 1'b1;
    vecs[6].code = v;         vecs[6].fine = 102;
    vecs[7].code = ones(199); vecs[7].fine = 199;

    rst_n = 1'b1; en = 1'b1; ts_ready = 1'b1; therm_in = '0;
    @(negedge clk);
    doReset();

    // Coarse reaches 100, then a 37-tap code
    while (m_cyc != 100) applyStimulus('0, 1'b1, 1'b1);
    applyStimulus(ones(37), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1, 1'b1);
    checkOutput("t1_valid", 32'(ts_valid), 32'd1);
    checkOutput("t1_coarse", 32'(ts_coarse), 32'd100);
    checkOutput("t1_fine", 32'(ts_fine), 32'd37);

    foreach (vecs[n]) begin
      applyStimulus('0, 1'b1, 1'b1);
      cyc_at_hit = m_cyc;
      applyStimulus(vecs[n].code, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1, 1'b1);
      checkOutput($sformatf("vec%0d_valid", n), 32'(ts_valid), 32'd1);
      checkOutput($sformatf("vec%0d_fine", n), 32'(ts_fine), 32'(vecs[n].fine));
      checkOutput($sformatf("vec%0d_coarse", n), 32'(ts_coarse), 32'(cyc_at_hit));
    end

    // All ones held high for five cycles gives exactly one timestamp
    applyStimulus('0, 1'b1, 1'b1);
    seen = 0; seen_fine = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i < 5) ? '1 : '0, 1'b1, 1'b1);
      if (ts_valid) begin seen++; seen_fine = int'(ts_fine); end
    end
    checkOutput("t3_count", 32'(seen), 32'd1);
    checkOutput("t3_fine", 32'(seen_fine), 32'd200);

    // Backpressure: second hit dropped, first held
    doReset();
    applyStimulus('0, 1'b1, 1'b0);
    applyStimulus(ones(20), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1, 1'b0);
    applyStimulus(ones(30), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus('0, 1'b1, 1'b0);
    checkOutput("t4_valid", 32'(ts_valid), 32'd1);
    checkOutput("t4_fine", 32'(ts_fine), 32'd20);
    checkOutput("t4_drop", 32'(drop_cnt), 32'd1);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("t4_after_hs", 32'(ts_valid), 32'd0);

    // Narrow coarse counter wraps between two hits
    applyStimulus('0, 1'b1, 1'b1);
    while ((m_cyc % 16) != 15) applyStimulus('0, 1'b1, 1'b1);
    applyStimulus(ones(5), 1'b1, 1'b1);
    applyStimulus('0, 1'b1, 1'b1);
    applyStimulus(ones(6), 1'b1, 1'b1);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("t5_first", 32'(w4_coarse), 32'd15);
    applyStimulus('0, 1'b1, 1'b1);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("t5_second", 32'(w4_coarse), 32'd1);
    checkOutput("t5_fine", 32'(w4_fine), 32'd6);

    // Disabled: back-to-back hits ignored
    for (int i = 0; i < 8; i++) applyStimulus((i % 2 == 1) ? ones(10) : '0, 1'b0, 1'b1);
    checkOutput("t6_en_off", 32'(ts_valid), 32'd0);

    // Reset one cycle after a hit discards it
    applyStimulus(ones(60), 1'b1, 1'b1);
    applyStimulus('0, 1'b1, 1'b1);
    doReset();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus('0, 1'b1, 1'b1);
      if (ts_valid) seen++;
    end
    checkOutput("t6_rst_valid", 32'(seen), 32'd0);
    checkOutput("t6_rst_drop", 32'(drop_cnt), 32'd0);

    // Random traffic with bubbles, enable gaps and backpressure
    for (int n = 0; n < 400; n++) begin
      logic e, r;
      if ($urandom_range(2) == 0) begin
        v = '0;
      end else begin
        v = ones(int'($urandom_range(NFF)));
        for (int f = 0; f < int'($urandom_range(3)); f++) begin
          int idx;
          idx = int'($urandom_range(NFF-1));
          v[idx] = ~v[idx];
        end
      end
      e = ($urandom_range(9) != 0);
      r = ($urandom_range(9) < 7);
      applyStimulus(v, e, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
